raizing_pal_arb: RTL and testbench
==================================

# raizing_pal_arb

Single-port palette RAM arbiter for the Raizing video path. It shares one 2048×16 palette RAM between three requesters: the pixel pipeline, the 68000 CPU and a power-up clear engine. The pixel pipeline gets a fixed, jitter-free read slot on every pixel enable. The CPU and the clear engine use the remaining CLK96 cycles. It sits between the CPU bus decode, the palette BRAM and the colour-expansion/blanking stage.

## Interface
Parameters:
- AW, 11, palette address width (2^AW entries)
- DW, 16, palette word width (xBGR555)

Ports:
- CLK96  in  1  sole clock; all logic on posedge
- RESET_N  in  1  asynchronous, active-low reset
- PIXEL_CEN  in  1  pixel enable, one CLK96 cycle wide; consecutive pulses at least 3 cycles apart
- PIXEL  in  AW  palette index, sampled when PIXEL_CEN=1
- PIX_DATA  out  DW  palette word for the last sampled PIXEL
- PIX_VALID  out  1  one-cycle pulse when PIX_DATA updates
- CPU_CS  in  1  CPU request; held high until CPU_OK, then dropped
- CPU_WE  in  1  1=write, 0=read; stable while CPU_CS=1
- CPU_ADDR  in  AW  word address
- CPU_DIN  in  DW  write data
- CPU_BE  in  2  byte enables {upper, lower}, active-high
- CPU_DOUT  out  DW  read data, valid when CPU_OK=1 on a read
- CPU_OK  out  1  one-cycle completion pulse
- BUSY  out  1  clear engine active
- RAM_ADDR  out  AW  RAM address (registered)
- RAM_DIN  out  DW  RAM write data (registered)
- RAM_WE  out  2  RAM byte write enables (registered)
- RAM_Q  in  DW  RAM read data, 1-cycle synchronous read latency

## Operation
- Each CLK96 edge grants at most one RAM access. Priority, highest first:
  - video (PIXEL_CEN=1)
  - clear engine (BUSY=1)
  - CPU (CPU_CS=1, CPU FSM in C_IDLE, BUSY=0)
- Video grant:
  - RAM_ADDR<=PIXEL, RAM_WE<=0.
  - A 2-stage tag pipe marks the matching RAM_Q cycle. PIX_DATA<=RAM_Q at that edge and PIX_VALID pulses.
  - Video is never stalled.
- Clear engine:
  - After reset, BUSY=1 and counter CLR=0.
  - Each clear grant drives RAM_ADDR<=CLR, RAM_DIN<=0, RAM_WE<=2'b11, then CLR increments.
  - After the grant with CLR=2^AW−1, BUSY<=0 on the same edge. The counter does not wrap or restart until the next reset.
  - A video cycle skips that clear slot; CLR does not advance.
- CPU FSM states: C_IDLE, C_RD, C_HOLD.
  - C_IDLE, granted write: RAM_ADDR/RAM_DIN<=CPU_ADDR/CPU_DIN, RAM_WE<=CPU_BE. CPU_OK pulses on the next edge, then go to C_HOLD.
  - C_IDLE, granted read: RAM_ADDR<=CPU_ADDR, RAM_WE<=0, go to C_RD.
  - C_RD: wait one cycle. Then CPU_DOUT<=RAM_Q and CPU_OK pulses on the same edge as the capture, then go to C_HOLD. CPU_DOUT holds until the next read.
  - C_HOLD: no new grant until CPU_CS=0, then go to C_IDLE. One access per CS assertion.
  - A CPU write with CPU_BE=0 is still granted and acknowledged. No RAM byte is modified.
- RAM_WE is a single-cycle strobe. It returns to 0 on every edge without a write grant.
- A CPU read in C_RD is unaffected by a video grant in the following cycle, because the read tag pipe is separate from the video tag pipe.

## Timing
- Reset values:
  - RAM_ADDR=0, RAM_DIN=0, RAM_WE=0
  - PIX_DATA=0, PIX_VALID=0
  - CPU_DOUT=0, CPU_OK=0
  - BUSY=1, CLR=0, CPU FSM=C_IDLE
- Reset asserted mid-clear or mid-CPU access aborts everything. The clear restarts from 0 and no CPU_OK is issued.
- Video latency is fixed. PIXEL_CEN is sampled at edge E0, the address is driven after E0, RAM_Q is valid after E1, and PIX_DATA/PIX_VALID update at E2.
- CPU write latency is 1 edge from grant to CPU_OK. CPU read latency is 2 edges from grant to CPU_OK.
- CPU worst-case wait: during BUSY it is unbounded until the clear ends. Otherwise it is at most 1 cycle of video pre-emption per grant attempt.
- Clear duration is 2^AW plus the number of video cycles that occur during the clear (~2048+ cycles).
- Simultaneous events: PIXEL_CEN and CPU_CS both high on the same cycle gives video the grant and the CPU the next free cycle. CPU_CS during BUSY is held pending, with no OK.
- Read-after-write to the same address returns the new data, since the RAM write completes before the later read grant.

## Test plan
- Reset release with no requests: BUSY stays high 2048 cycles with RAM_WE=2'b11 and addresses 0..0x7FF in order, then BUSY=0 with no further writes.
- PIXEL_CEN every 8 cycles during the clear: each video read returns PIX_VALID exactly 2 edges after the enable, BUSY still drops, and all 2048 addresses are cleared exactly once.
- After the clear, CPU writes 0x7C1F to 0x123 with BE=2'b11 and CPU_OK 1 edge after the grant. A CPU read of 0x123 then gives CPU_DOUT=0x7C1F, and PIXEL=0x123 gives PIX_DATA=0x7C1F.
- Byte-enable write 0x00AA with BE=2'b01 over 0x7C1F: the read returns 0x7CAA.
- PIXEL_CEN and CPU_CS rise on the same cycle: RAM_ADDR shows PIXEL first and the CPU address next cycle. PIX_VALID timing is unchanged, and CPU_OK is delayed by 1 cycle.
- RESET_N pulsed low while CPU_CS is held in C_RD and the clear is at 0x400: no CPU_OK is issued, and after release BUSY=1 with the clear restarting at address 0.

Source files
------------

// File: rtl/raizing_pal_arb.sv
// Purpose : shares one single-port palette RAM between video reads, the power-up clear engine and the CPU.
// Latency : video PIXEL_CEN -> PIX_VALID 2 edges; CPU write grant -> CPU_OK 1 edge; CPU read grant -> CPU_OK 2 edges.
// Backpressure: video is never stalled; the clear engine yields to video; the CPU waits (CPU_CS held) for any free slot.
//
// Ports:
//   CLK96, RESET_N                  clock, async active-low reset
//   PIXEL_CEN/PIXEL -> PIX_DATA/PIX_VALID   fixed-latency video palette lookup
//   CPU_CS/WE/ADDR/DIN/BE -> CPU_DOUT/OK    one access per CS assertion
//   BUSY                            clear engine running
//   RAM_ADDR/RAM_DIN/RAM_WE/RAM_Q   registered RAM port, 1-cycle read latency
module raizing_pal_arb #(
  parameter int AW = 11,
  parameter int DW = 16
) (
  input  logic          CLK96,
  input  logic          RESET_N,
  input  logic          PIXEL_CEN,
  input  logic [AW-1:0] PIXEL,
  output logic [DW-1:0] PIX_DATA,
  output logic          PIX_VALID,
  input  logic          CPU_CS,
  input  logic          CPU_WE,
  input  logic [AW-1:0] CPU_ADDR,
  input  logic [DW-1:0] CPU_DIN,
  input  logic [1:0]    CPU_BE,
  output logic [DW-1:0] CPU_DOUT,
  output logic          CPU_OK,
  output logic          BUSY,
  output logic [AW-1:0] RAM_ADDR,
  output logic [DW-1:0] RAM_DIN,
  output logic [1:0]    RAM_WE,
  input  logic [DW-1:0] RAM_Q
);

  typedef enum logic [1:0] {C_IDLE, C_RD, C_HOLD} cpu_st_t;

  cpu_st_t       st_q, st_d;
  logic [AW-1:0] clr_q, clr_d;
  logic          busy_q, busy_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_din_q, ram_din_d;
  logic [1:0]    ram_we_q, ram_we_d;
  // Separate tag pipes so a CPU read in flight is not disturbed by a video
  // grant that lands in the cycle after it.
  logic [1:0]    vtag_q, vtag_d;
  logic [1:0]    rtag_q, rtag_d;
  logic          wr_ack_q, wr_ack_d;
  logic [DW-1:0] pix_data_q, pix_data_d;
  logic          pix_valid_q, pix_valid_d;
  logic [DW-1:0] cpu_dout_q, cpu_dout_d;
  logic          cpu_ok_q, cpu_ok_d;

  logic vid_gnt, clr_gnt, cpu_gnt;

  always_comb begin
    vid_gnt = PIXEL_CEN;
    clr_gnt = !PIXEL_CEN && busy_q;
    cpu_gnt = !PIXEL_CEN && !busy_q && CPU_CS && (st_q == C_IDLE);

    st_d        = st_q;
    clr_d       = clr_q;
    busy_d      = busy_q;
    ram_addr_d  = ram_addr_q;
    ram_din_d   = ram_din_q;
    ram_we_d    = 2'b00;              // write strobe lasts one cycle only
    vtag_d      = {vtag_q[0], vid_gnt};
    rtag_d      = {rtag_q[0], 1'b0};
    wr_ack_d    = 1'b0;
    pix_data_d  = pix_data_q;
    pix_valid_d = 1'b0;
    cpu_dout_d  = cpu_dout_q;
    cpu_ok_d    = wr_ack_q;

    if (vid_gnt) begin
      ram_addr_d = PIXEL;
    end else if (clr_gnt) begin
      ram_addr_d = clr_q;
      ram_din_d  = '0;
      ram_we_d   = 2'b11;
      // Counter parks on the last address; only a reset restarts the clear.
      if (clr_q == {AW{1'b1}}) busy_d = 1'b0;
      else                     clr_d  = clr_q + AW'(1);
    end else if (cpu_gnt) begin
      ram_addr_d = CPU_ADDR;
      if (CPU_WE) begin
        ram_din_d = CPU_DIN;
        ram_we_d  = CPU_BE;
        wr_ack_d  = 1'b1;
      end else begin
        rtag_d[0] = 1'b1;
      end
    end

    if (vtag_q[1]) begin
      pix_data_d  = RAM_Q;
      pix_valid_d = 1'b1;
    end

    if (rtag_q[1]) begin
      cpu_dout_d = RAM_Q;
      cpu_ok_d   = 1'b1;
    end

    case (st_q)
      C_IDLE: if (cpu_gnt) st_d = CPU_WE ? C_HOLD : C_RD;
      C_RD:   if (rtag_q[1]) st_d = C_HOLD;
      C_HOLD: if (!CPU_CS) st_d = C_IDLE;
      default: st_d = C_IDLE;
    endcase
  end

  always_ff @(posedge CLK96 or negedge RESET_N) begin
    if (!RESET_N) begin
      st_q        <= C_IDLE;
      clr_q       <= '0;
      busy_q      <= 1'b1;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      ram_we_q    <= 2'b00;
      vtag_q      <= 2'b00;
      rtag_q      <= 2'b00;
      wr_ack_q    <= 1'b0;
      pix_data_q  <= '0;
      pix_valid_q <= 1'b0;
      cpu_dout_q  <= '0;
      cpu_ok_q    <= 1'b0;
    end else begin
      st_q        <= st_d;
      clr_q       <= clr_d;
      busy_q      <= busy_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      ram_we_q    <= ram_we_d;
      vtag_q      <= vtag_d;
      rtag_q      <= rtag_d;
      wr_ack_q    <= wr_ack_d;
      pix_data_q  <= pix_data_d;
      pix_valid_q <= pix_valid_d;
      cpu_dout_q  <= cpu_dout_d;
      cpu_ok_q    <= cpu_ok_d;
    end
  end

  assign PIX_DATA  = pix_data_q;
  assign PIX_VALID = pix_valid_q;
  assign CPU_DOUT  = cpu_dout_q;
  assign CPU_OK    = cpu_ok_q;
  assign BUSY      = busy_q;
  assign RAM_ADDR  = ram_addr_q;
  assign RAM_DIN   = ram_din_q;
  assign RAM_WE    = ram_we_q;

endmodule

// File: tb/tb_raizing_pal_arb.sv
// Bench for raizing_pal_arb: palette RAM model plus a per-cycle reference
// model of grants, clear progress, video returns and CPU completions.
module tb_raizing_pal_arb;
  localparam int DEPTH = 2048;

  logic        CLK96 = 1'b0;
  logic        RESET_N;
  logic        PIXEL_CEN = 1'b0;
  logic [10:0] PIXEL = '0;
  logic [15:0] PIX_DATA;
  logic        PIX_VALID;
  logic        CPU_CS = 1'b0;
  logic        CPU_WE = 1'b0;
  logic [10:0] CPU_ADDR = '0;
  logic [15:0] CPU_DIN = '0;
  logic [1:0]  CPU_BE = '0;
  logic [15:0] CPU_DOUT;
  logic        CPU_OK;
  logic        BUSY;
  logic [10:0] RAM_ADDR;
  logic [15:0] RAM_DIN;
  logic [1:0]  RAM_WE;
  logic [15:0] RAM_Q = '0;

  raizing_pal_arb #(.AW(11), .DW(16)) dut (
    .CLK96(CLK96), .RESET_N(RESET_N),
    .PIXEL_CEN(PIXEL_CEN), .PIXEL(PIXEL), .PIX_DATA(PIX_DATA), .PIX_VALID(PIX_VALID),
    .CPU_CS(CPU_CS), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_DIN(CPU_DIN), .CPU_BE(CPU_BE),
    .CPU_DOUT(CPU_DOUT), .CPU_OK(CPU_OK), .BUSY(BUSY),
    .RAM_ADDR(RAM_ADDR), .RAM_DIN(RAM_DIN), .RAM_WE(RAM_WE), .RAM_Q(RAM_Q)
  );

  always #5 CLK96 = ~CLK96;

  function automatic logic [15:0] junk(input int i);
    return 16'(i * 40503 + 12345);
  endfunction

  // Palette BRAM: read-first, byte-writable, not affected by RESET_N.
  logic [15:0] mem [DEPTH];
  bit          mem_filled;
  always @(posedge CLK96) begin
    if (!mem_filled) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= junk(i);
      mem_filled <= 1'b1;
    end else begin
      RAM_Q <= mem[RAM_ADDR];
      if (RAM_WE[0]) mem[RAM_ADDR][7:0]  <= RAM_DIN[7:0];
      if (RAM_WE[1]) mem[RAM_ADDR][15:8] <= RAM_DIN[15:8];
    end
  end

  // Reference model state
  typedef struct { int due; logic [15:0] val; } pexp_t;
  pexp_t       pq[$];
  logic [15:0] ref_mem [DEPTH];
  int          clr_done;
  bit          served;
  int          ok_due = -1;
  bit          is_rd;
  logic [15:0] exp_dout;
  int          cyc;
  int          last_pix = -100;
  int          pix_mode;
  bit          pix_force;
  logic [10:0] pix_force_addr;
  int          obs_clr_wr;
  int          total, bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    logic vg, cg, pg, cs_pre, we_pre, busy_pre;
    logic [10:0] pa, ca;
    logic [15:0] cd;
    logic [1:0]  cbe;
    if (pix_force) begin
      PIXEL_CEN = 1'b1; PIXEL = pix_force_addr; pix_force = 1'b0; last_pix = cyc;
    end else if (pix_mode == 1 && (cyc % 8) == 0 && cyc - last_pix >= 3) begin
      PIXEL_CEN = 1'b1; PIXEL = 11'($urandom); last_pix = cyc;
    end else if (pix_mode == 2 && cyc - last_pix >= 3 && $urandom_range(0, 2) == 0) begin
      PIXEL_CEN = 1'b1; PIXEL = 11'h100 + 11'($urandom_range(0, 7)); last_pix = cyc;
    end else begin
      PIXEL_CEN = 1'b0;
    end
    busy_pre = (clr_done < DEPTH);
    vg = PIXEL_CEN; pa = PIXEL;
    cg = !vg && busy_pre;
    pg = !vg && !cg && CPU_CS && !served;
    cs_pre = CPU_CS; we_pre = CPU_WE; ca = CPU_ADDR; cd = CPU_DIN; cbe = CPU_BE;
    @(posedge CLK96);
    #1;
    cyc++;
    if (vg) begin
      chk("vid_addr", 32'(RAM_ADDR), 32'(pa));
      chk("vid_we", 32'(RAM_WE), 0);
      pq.push_back('{cyc + 2, ref_mem[pa]});
    end else if (cg) begin
      chk("clr_addr", 32'(RAM_ADDR), clr_done);
      chk("clr_we", 32'(RAM_WE), 3);
      chk("clr_din", 32'(RAM_DIN), 0);
      ref_mem[clr_done[10:0]] = '0;
      clr_done++;
    end else if (pg) begin
      chk("cpu_addr", 32'(RAM_ADDR), 32'(ca));
      served = 1'b1;
      if (we_pre) begin
        chk("cpu_we", 32'(RAM_WE), 32'(cbe));
        chk("cpu_din", 32'(RAM_DIN), 32'(cd));
        if (cbe[0]) ref_mem[ca][7:0]  = cd[7:0];
        if (cbe[1]) ref_mem[ca][15:8] = cd[15:8];
        ok_due = cyc + 1; is_rd = 1'b0;
      end else begin
        chk("cpu_rd_we", 32'(RAM_WE), 0);
        exp_dout = ref_mem[ca];
        ok_due = cyc + 2; is_rd = 1'b1;
      end
    end else begin
      chk("idle_we", 32'(RAM_WE), 0);
    end
    if (!cs_pre) served = 1'b0;
    if (busy_pre && RAM_WE === 2'b11) obs_clr_wr++;
    if (pq.size() > 0 && pq[0].due == cyc) begin
      chk("pix_valid", 32'(PIX_VALID), 1);
      chk("pix_data", 32'(PIX_DATA), 32'(pq[0].val));
      void'(pq.pop_front());
    end else begin
      chk("pix_valid_idle", 32'(PIX_VALID), 0);
    end
    chk("cpu_ok", 32'(CPU_OK), 32'(cyc == ok_due));
    if (cyc == ok_due && is_rd) chk("cpu_dout", 32'(CPU_DOUT), 32'(exp_dout));
    chk("busy", 32'(BUSY), 32'(clr_done < DEPTH));
  endtask

  task automatic cpu_access(input logic we, input logic [10:0] a, input logic [15:0] d,
                            input logic [1:0] be, input logic with_pix, input logic [10:0] pa,
                            input int bound, output int lat);
    CPU_CS = 1'b1; CPU_WE = we; CPU_ADDR = a; CPU_DIN = d; CPU_BE = be;
    if (with_pix) begin pix_force = 1'b1; pix_force_addr = pa; end
    lat = 0;
    do begin tick(); lat++; end while (CPU_OK !== 1'b1 && lat < bound);
    chk("cpu_ok_seen", 32'(CPU_OK), 1);
    CPU_CS = 1'b0;
    tick();
  endtask

  task automatic pulse_reset();
    RESET_N = 1'b0; CPU_CS = 1'b0; PIXEL_CEN = 1'b0;
    #1;
    chk("rst_ram_addr", 32'(RAM_ADDR), 0);
    chk("rst_ram_din", 32'(RAM_DIN), 0);
    chk("rst_ram_we", 32'(RAM_WE), 0);
    chk("rst_pix_data", 32'(PIX_DATA), 0);
    chk("rst_pix_valid", 32'(PIX_VALID), 0);
    chk("rst_cpu_dout", 32'(CPU_DOUT), 0);
    chk("rst_cpu_ok", 32'(CPU_OK), 0);
    chk("rst_busy", 32'(BUSY), 1);
    repeat (2) @(posedge CLK96);
    #1;
    chk("rst_hold_ok", 32'(CPU_OK), 0);
    RESET_N = 1'b1;
    clr_done = 0; served = 1'b0; ok_due = -1; pq.delete(); obs_clr_wr = 0;
  endtask

  initial begin
    int lat;
    RESET_N = 1'b1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = junk(i);
    #2;
    pulse_reset();

    // Clear with video every 8 cycles and a CPU write pending throughout.
    pix_mode = 1;
    cpu_access(1'b1, 11'h055, 16'h1234, 2'b11, 1'b0, '0, 4000, lat);
    chk("clr_write_count", obs_clr_wr, DEPTH);
    pix_mode = 0;
    repeat (4) tick();

    // Full write then read back through CPU and video.
    cpu_access(1'b1, 11'h123, 16'h7C1F, 2'b11, 1'b0, '0, 20, lat);
    chk("wr_latency", lat, 2);
    cpu_access(1'b0, 11'h123, '0, 2'b00, 1'b0, '0, 20, lat);
    chk("rd_latency", lat, 3);
    chk("rd_123", 32'(CPU_DOUT), 32'h7C1F);
    repeat (3) tick();
    pix_force = 1'b1; pix_force_addr = 11'h123;
    repeat (4) tick();
    chk("pix_123", 32'(PIX_DATA), 32'h7C1F);

    // Low-byte-only write.
    cpu_access(1'b1, 11'h123, 16'h00AA, 2'b01, 1'b0, '0, 20, lat);
    cpu_access(1'b0, 11'h123, '0, 2'b00, 1'b0, '0, 20, lat);
    chk("rd_be01", 32'(CPU_DOUT), 32'h7CAA);

    // Zero byte-enable write is acknowledged but changes nothing.
    cpu_access(1'b1, 11'h123, 16'hFFFF, 2'b00, 1'b0, '0, 20, lat);
    cpu_access(1'b0, 11'h123, '0, 2'b00, 1'b0, '0, 20, lat);
    chk("rd_be00", 32'(CPU_DOUT), 32'h7CAA);

    // Video and CPU request on the same cycle: video first, CPU one late.
    repeat (4) tick();
    cpu_access(1'b0, 11'h123, '0, 2'b00, 1'b1, 11'h055, 20, lat);
    chk("collide_rd_latency", lat, 4);
    chk("collide_dout", 32'(CPU_DOUT), 32'h7CAA);

    // Random traffic against background video on a small address window.
    pix_mode = 2;
    for (int k = 0; k < 60; k++) begin
      cpu_access(1'($urandom_range(0, 1)), 11'h100 + 11'($urandom_range(0, 7)),
                 16'($urandom), 2'($urandom_range(0, 3)), 1'b0, '0, 20, lat);
      repeat ($urandom_range(0, 3)) tick();
    end
    pix_mode = 0;
    repeat (4) tick();

    // Reset in the middle of a CPU read: no completion, clear restarts at 0.
    CPU_CS = 1'b1; CPU_WE = 1'b0; CPU_ADDR = 11'h123;
    tick();
    chk("rd_in_flight_ok", 32'(CPU_OK), 0);
    pulse_reset();
    tick();
    chk("clr_restart_addr", 32'(RAM_ADDR), 0);
    pix_mode = 1;
    for (int n = 0; n < 3000 && clr_done < 'h400; n++) tick();
    chk("clr_reached_400", clr_done, 'h400);

    // Reset mid-clear: restarts from 0 and completes again.
    pix_mode = 0;
    pulse_reset();
    tick();
    chk("clr_restart2_addr", 32'(RAM_ADDR), 0);
    chk("clr_restart2_we", 32'(RAM_WE), 3);
    pix_mode = 1;
    for (int n = 0; n < 3000 && BUSY === 1'b1; n++) tick();
    chk("clr2_done", 32'(BUSY), 0);
    chk("clr2_write_count", obs_clr_wr, DEPTH);
    pix_mode = 0;
    repeat (6) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
